// File: rtl/amt_repair_ctrl.sv
// amt_repair_ctrl: after a recovery, walks the AMT in packets and rewrites
// the RMT, holding off AMT commit until the last packet has landed.
module amt_repair_ctrl #(
  parameter int DEPTH     = 34,
  parameter int INDEX     = 6,
  parameter int WIDTH     = 7,
  parameter int N_PACKETS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       recover_i,
  output logic [INDEX*N_PACKETS-1:0] repairAddr_o,
  input  logic [WIDTH*N_PACKETS-1:0] repairData_i,
  output logic                       repairFlag_o,
  output logic [INDEX*N_PACKETS-1:0] rmtWrAddr_o,
  output logic [WIDTH*N_PACKETS-1:0] rmtWrData_o,
  output logic [N_PACKETS-1:0]       rmtWe_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       commitStall_o
);

  localparam int BW = INDEX + 1;
  localparam logic [BW-1:0] STEP  = BW'(N_PACKETS);
  localparam logic [BW-1:0] LIMIT = BW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    DRAIN
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [BW-1:0]        base;
  logic [BW-1:0]        base_n;
  logic [BW-1:0]        lane_sum [N_PACKETS];
  logic [N_PACKETS-1:0] lane_ok;
  logic                 last;

  always_comb begin
    lane_ok = '0;
    for (int i = 0; i < N_PACKETS; i++) begin
      lane_sum[i] = base + BW'(i);
      lane_ok[i]  = lane_sum[i] < LIMIT;
    end
  end

  // one extra bit so base+STEP cannot wrap before the compare
  assign last = ({1'b0, base} + {1'b0, STEP}) >= {1'b0, LIMIT};

  always_comb begin
    state_n      = state;
    base_n       = base;
    repairFlag_o = 1'b0;
    repairAddr_o = '0;
    done_o       = 1'b0;
    unique case (state)
      IDLE: begin
        if (recover_i) begin
          state_n = WALK;
          base_n  = '0;
        end
      end
      WALK: begin
        repairFlag_o = 1'b1;
        for (int i = 0; i < N_PACKETS; i++) begin
          if (lane_ok[i]) begin
            repairAddr_o[i*INDEX +: INDEX] = lane_sum[i][INDEX-1:0];
          end
        end
        if (recover_i) begin
          base_n = '0;
        end else if (last) begin
          state_n = DRAIN;
        end else begin
          base_n = base + STEP;
        end
      end
      DRAIN: begin
        done_o = !recover_i;
        if (recover_i) begin
          state_n = WALK;
          base_n  = '0;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy_o        = state != IDLE;
  assign commitStall_o = busy_o | recover_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      base        <= '0;
      rmtWe_o     <= '0;
      rmtWrAddr_o <= '0;
      rmtWrData_o <= '0;
    end else begin
      state <= state_n;
      base  <= base_n;
      if (state == WALK) begin
        rmtWe_o <= lane_ok;
        // invalid lanes carry zeros so no out-of-range index ever leaves
        for (int i = 0; i < N_PACKETS; i++) begin
          rmtWrAddr_o[i*INDEX +: INDEX] <=
            lane_ok[i] ? lane_sum[i][INDEX-1:0] : '0;
          rmtWrData_o[i*WIDTH +: WIDTH] <=
            lane_ok[i] ? repairData_i[i*WIDTH +: WIDTH] : '0;
        end
      end else begin
        rmtWe_o     <= '0;
        rmtWrAddr_o <= '0;
        rmtWrData_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_amt_repair_ctrl.sv
// tb_amt_repair_ctrl: two instances (DEPTH 34 and 32) against a timing
// model of the walk and a write-packet scoreboard.
module tb_amt_repair_ctrl;

  localparam int IX = 6;
  localparam int W  = 7;
  localparam int N  = 8;
  localparam int DA = 34;
  localparam int DB = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic recover = 1'b0;

  logic [IX*N-1:0] addr_a, addr_b, waddr_a, waddr_b;
  logic [W*N-1:0]  rdata_a, rdata_b, wdata_a, wdata_b;
  logic [N-1:0]    we_a, we_b;
  logic flag_a, flag_b, busy_a, busy_b;
  logic done_a, done_b, stall_a, stall_b;

  always #5 clk = ~clk;

  amt_repair_ctrl #(
    .DEPTH(DA), .INDEX(IX), .WIDTH(W), .N_PACKETS(N)
  ) dut_a (
    .clk(clk), .reset(reset), .recover_i(recover),
    .repairAddr_o(addr_a), .repairData_i(rdata_a),
    .repairFlag_o(flag_a), .rmtWrAddr_o(waddr_a),
    .rmtWrData_o(wdata_a), .rmtWe_o(we_a), .busy_o(busy_a),
    .done_o(done_a), .commitStall_o(stall_a)
  );

  amt_repair_ctrl #(
    .DEPTH(DB), .INDEX(IX), .WIDTH(W), .N_PACKETS(N)
  ) dut_b (
    .clk(clk), .reset(reset), .recover_i(recover),
    .repairAddr_o(addr_b), .repairData_i(rdata_b),
    .repairFlag_o(flag_b), .rmtWrAddr_o(waddr_b),
    .rmtWrData_o(wdata_b), .rmtWe_o(we_b), .busy_o(busy_b),
    .done_o(done_b), .commitStall_o(stall_b)
  );

  typedef struct packed {
    int              cyc;
    logic [N-1:0]    we;
    logic [IX*N-1:0] addr;
    logic [W*N-1:0]  data;
  } wr_t;

  logic [W-1:0] amt [2][64];
  wr_t wq [2][$];
  int  ws [2];
  int  cyc;
  int  vectors;
  int  miscompares;
  bit  checking;

  // AMT RAM: combinational read from the repair address ports
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < N; i++) begin
      rdata_a[i*W +: W] = amt[0][addr_a[i*IX +: IX]];
      rdata_b[i*W +: W] = amt[1][addr_b[i*IX +: IX]];
    end
  end

  function automatic int dep(input int d);
    return (d == 0) ? DA : DB;
  endfunction

  function automatic int npk(input int d);
    return (dep(d) + N - 1) / N;
  endfunction

  function automatic bit is_busy(input int d, input int c);
    int k;
    k = (ws[d] >= 0) ? c - ws[d] : -1;
    return (k >= 1) && (k <= npk(d) + 1);
  endfunction

  task automatic cancel_after(input int d, input int lim);
    while (wq[d].size() > 0 && wq[d][wq[d].size()-1].cyc > lim)
      void'(wq[d].pop_back());
  endtask

  task automatic issue_recover(input int c);
    wr_t w;
    int  e;
    for (int d = 0; d < 2; d++) begin
      cancel_after(d, c + 1);
      for (int p = 0; p < npk(d); p++) begin
        w.cyc  = c + 2 + p;
        w.we   = '0;
        w.addr = '0;
        w.data = '0;
        for (int i = 0; i < N; i++) begin
          e = p * N + i;
          if (e < dep(d)) begin
            w.we[i] = 1'b1;
            w.addr[i*IX +: IX] = IX'(e);
            w.data[i*W +: W]   = amt[d][e];
          end
        end
        wq[d].push_back(w);
      end
    end
  endtask

  task automatic step(input bit rec, input bit rst, input bit shuffle);
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (reset) ws[d] = -1;
      else if (recover) ws[d] = cyc - 1;
    end
    #1;
    if (shuffle && !is_busy(0, cyc) && !is_busy(1, cyc)) begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 64; k++)
          amt[d][k] = W'($urandom);
    end
    reset   = rst;
    recover = rec;
    if (rst) begin
      cancel_after(0, cyc);
      cancel_after(1, cyc);
    end else if (rec) begin
      issue_recover(cyc);
    end
  endtask

  task automatic cmp1(input string nm, input int d,
                      input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s dut%0d cycle %0d: got %b required %b",
               nm, d, cyc, act, req);
    end
  endtask

  task automatic check_dut(
    input int d, input logic flag, input logic busy,
    input logic done, input logic stall, input logic [IX*N-1:0] addr,
    input logic [N-1:0] we, input logic [IX*N-1:0] waddr,
    input logic [W*N-1:0] wdata);
    int k, p, e;
    bit walk, drain;
    logic [IX*N-1:0] ea, am;
    logic [W*N-1:0] dm;
    wr_t w;
    p = npk(d);
    k = (ws[d] >= 0) ? cyc - ws[d] : -1;
    walk  = (k >= 1) && (k <= p);
    drain = (k == p + 1);
    ea = '0;
    if (walk) begin
      for (int i = 0; i < N; i++) begin
        e = (k - 1) * N + i;
        if (e < dep(d)) ea[i*IX +: IX] = IX'(e);
      end
    end
    cmp1("flag", d, flag, walk);
    cmp1("busy", d, busy, walk || drain);
    cmp1("done", d, done, drain && !recover);
    cmp1("stall", d, stall, walk || drain || recover);
    vectors++;
    if (addr !== ea) begin
      miscompares++;
      $display("FAIL rd_addr dut%0d cycle %0d: got %h required %h",
               d, cyc, addr, ea);
    end
    while (wq[d].size() > 0 && wq[d][0].cyc < cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL wr_missed dut%0d cycle %0d: got none required cycle %0d",
               d, cyc, wq[d][0].cyc);
      void'(wq[d].pop_front());
    end
    if (we != '0) begin
      vectors++;
      if (wq[d].size() == 0 || wq[d][0].cyc != cyc) begin
        miscompares++;
        $display("FAIL wr_extra dut%0d cycle %0d: got we %h required none",
                 d, cyc, we);
      end else begin
        w  = wq[d].pop_front();
        am = '0;
        dm = '0;
        for (int i = 0; i < N; i++) begin
          if (w.we[i]) begin
            am[i*IX +: IX] = waddr[i*IX +: IX];
            dm[i*W +: W]   = wdata[i*W +: W];
          end
        end
        if (we !== w.we || am !== w.addr || dm !== w.data) begin
          miscompares++;
          $display("FAIL wr_pkt dut%0d cycle %0d: got %h/%h/%h required %h/%h/%h",
                   d, cyc, we, am, dm, w.we, w.addr, w.data);
        end
      end
    end else if (wq[d].size() > 0 && wq[d][0].cyc == cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL wr_absent dut%0d cycle %0d: got we 0 required %h",
               d, cyc, wq[d][0].we);
      void'(wq[d].pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check_dut(0, flag_a, busy_a, done_a, stall_a, addr_a,
                we_a, waddr_a, wdata_a);
      check_dut(1, flag_b, busy_b, done_b, stall_b, addr_b,
                we_b, waddr_b, wdata_b);
    end
  end

  initial begin
    int r;
    bit rst, rec;
    ws[0] = -1;
    ws[1] = -1;
    cyc = 0;
    vectors = 0;
    miscompares = 0;
    checking = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 64; k++)
        amt[d][k] = W'(k + 40);

    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checking = 1'b1;
    repeat (20) step(1'b0, 1'b0, 1'b0);

    // plain walk
    step(1'b1, 1'b0, 1'b0);
    repeat (9) step(1'b0, 1'b0, 1'b0);

    // restart three cycles into the walk
    step(1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0);

    // reset mid-walk, then a clean walk
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (9) step(1'b0, 1'b0, 1'b0);

    // recovery landing in the drain cycle of the 34-entry instance
    step(1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0);

    repeat (400) begin
      r   = int'($urandom_range(0, 99));
      rst = r < 2;
      rec = !rst && r < 14;
      step(rec, rst, 1'b1);
    end
    repeat (12) step(1'b0, 1'b0, 1'b0);

    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (wq[d].size() != 0) begin
        miscompares++;
        $display("FAIL wr_left dut%0d: got %0d pending required 0",
                 d, wq[d].size());
      end
    end
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
